multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_EN, default 1: 1 = memory states wait on mem_ready_i; 0 = mem_ready_i ignored, treated as 1.
REQ-002 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port opcode_i, input, 6: instruction[31:26] from the instruction register, valid from DECODE onward.
REQ-005 The block SHALL have port mem_ready_i, input, 1: unified memory completes the access this cycle.
REQ-006 The block SHALL have ports pc_write_o, pc_write_cond_o, i_or_d_o, mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o and alu_src_a_o, each output, 1: standard multicycle datapath controls.
REQ-007 The block SHALL have ports alu_src_b_o (output, 2: 00 B, 01 const 4, 10 sign/zero-ext imm, 11 ext imm<<2), alu_op_o (output, 2: 00 add, 01 sub, 10 funct, 11 immediate-logic) and pc_src_o (output, 2: 00 ALU, 01 ALUOut, 10 jump target).
REQ-008 The block SHALL have port logic_ext_o, output, 1: drives the sign-extend unit's logic_ext_i; 1 = zero-extend, 0 = sign-extend.
REQ-009 The block SHALL have port state_o, output, 4: current state encoding, debug only.

Function
REQ-010 Supported opcodes SHALL be R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, addi 0x08, andi 0x0C, ori 0x0D and j 0x02.
REQ-011 The FSM SHALL have the states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, IMM_EXEC=9, IMM_WB=10 and JUMP=11.
REQ-012 FETCH SHALL assert i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_src=00, and SHALL assert ir_write and pc_write only in the cycle mem_ready_i=1, holding FETCH while mem_ready_i=0.
REQ-013 DECODE SHALL assert alu_src_a=0, alu_src_b=11 and alu_op=00, then branch on opcode_i: lw/sw to MEM_ADDR, R-type to R_EXEC, beq to BRANCH, addi/andi/ori to IMM_EXEC, j to JUMP, and any other opcode to FETCH (NOP).
REQ-014 MEM_ADDR SHALL assert alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_READ (lw) or MEM_WRITE (sw).
REQ-015 MEM_READ SHALL assert i_or_d=1 and hold until mem_ready_i, then go to MEM_WB; MEM_WB SHALL assert reg_dst=0, mem_to_reg=1 and reg_write, then go to FETCH.
REQ-016 MEM_WRITE SHALL assert i_or_d=1 and mem_write while waiting, and SHALL go to FETCH on mem_ready_i.
REQ-017 R_EXEC SHALL assert alu_src_a=1, alu_src_b=00 and alu_op=10; R_WB SHALL assert reg_dst=1, mem_to_reg=0 and reg_write, then go to FETCH.
REQ-018 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01 and pc_write_cond, then go to FETCH.
REQ-019 IMM_EXEC SHALL assert alu_src_a=1, alu_src_b=10 and alu_op=00 (addi) or 11 (andi/ori); IMM_WB SHALL assert reg_dst=0, mem_to_reg=0 and reg_write, then go to FETCH.
REQ-020 JUMP SHALL assert pc_src=10 and pc_write, then go to FETCH.
REQ-021 The block SHALL latch opcode_i into an internal register on the DECODE cycle, and all later states SHALL use the latched value.
REQ-022 logic_ext_o SHALL be 1 only in MEM_ADDR, IMM_EXEC or IMM_WB with a latched opcode of andi or ori, and 0 otherwise.
REQ-023 All outputs not listed for a state SHALL be 0; outputs SHALL be Moore, decoded from the state and the latched opcode only, with no combinational path from mem_ready_i except ir_write/pc_write in FETCH.
REQ-024 Cycle counts with mem_ready_i tied to 1 SHALL be: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3, unknown 2.

Reset
REQ-025 Asserting reset SHALL immediately force state to FETCH, the latched opcode to 0x00 and all outputs except FETCH defaults to 0, including mid-instruction and during a memory wait.
REQ-026 The first rising clk edge after reset deasserts SHALL be evaluated in FETCH.

Structure
REQ-027 The state enumeration, opcode constants and alu_op/alu_src_b/pc_src encodings SHALL live in a shared package, mips_ctrl_pkg.
REQ-028 The block SHALL be one FSM with a separate combinational output decoder; a sub-module main_decoder (latched opcode -> next state from DECODE, logic_ext) is permitted.

Verification
REQ-029 Reset mid-MEM_READ -> state_o=0 immediately, all outputs 0 except FETCH controls, and the next fetch is correct.
REQ-030 andi (0x0C) with mem_ready_i=1 -> states 0,1,9,10,0; logic_ext_o=1 in 9 and 10; reg_write=1 only in 10.
REQ-031 lw (0x23) with mem_ready_i low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with mem_to_reg=1.
REQ-032 FETCH with mem_ready_i low for 2 cycles -> ir_write/pc_write asserted only in the third cycle.
REQ-033 Opcode 0x3F -> DECODE to FETCH, with no reg_write, mem_write or pc_write in DECODE.
REQ-034 beq (0x04) -> pc_write_cond=1, pc_src=01, alu_op=01 in state 8 only; j (0x02) -> pc_src=10, pc_write=1 in state 11.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes
// and the datapath mux/ALU select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD       = 2'b00;
  localparam logic [1:0] ALU_SUB       = 2'b01;
  localparam logic [1:0] ALU_FUNCT     = 2'b10;
  localparam logic [1:0] ALU_IMM_LOGIC = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  // andi/ori take a zero-extended immediate and the logic ALU op.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_main_decoder.sv
// Opcode dispatch out of DECODE and the zero/sign-extend select.
module main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] op_q,
  input  state_t     state,
  output state_t     decode_next,
  output logic       logic_ext
);

  // NOTE: every always_comb output gets a value on all paths (default first)
  // so no latch is inferred.
  always_comb begin
    decode_next = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:              decode_next = S_MEM_ADDR;
      OP_RTYPE:                  decode_next = S_R_EXEC;
      OP_BEQ:                    decode_next = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI:  decode_next = S_IMM_EXEC;
      OP_J:                      decode_next = S_JUMP;
      default:                   decode_next = S_FETCH;
    endcase
  end

  assign logic_ext = is_logic_imm(op_q) &&
                     (state inside {S_MEM_ADDR, S_IMM_EXEC, S_IMM_WB});

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state register plus a Moore output decoder,
// with only FETCH's ir_write/pc_write qualified by memory ready.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       logic_ext_o,
  output logic [3:0] state_o
);

  state_t     state;
  state_t     decode_next;
  logic [5:0] op_q;
  logic       ready;

  assign ready   = MEM_WAIT_EN ? mem_ready_i : 1'b1;
  assign state_o = state;

  main_decoder u_main_decoder (
    .opcode      (opcode_i),
    .op_q        (op_q),
    .state       (state),
    .decode_next (decode_next),
    .logic_ext   (logic_ext_o)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= OP_RTYPE;
    end else begin
      case (state)
        S_FETCH:     if (ready) state <= S_DECODE;
        S_DECODE: begin
          op_q  <= opcode_i;
          state <= decode_next;
        end
        S_MEM_ADDR:  state <= (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (ready) state <= S_MEM_WB;
        S_MEM_WRITE: if (ready) state <= S_FETCH;
        S_R_EXEC:    state <= S_R_WB;
        S_IMM_EXEC:  state <= S_IMM_WB;
        default:     state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRC_B_REG;
    alu_op_o        = ALU_ADD;
    pc_src_o        = PC_SRC_ALU;
    case (state)
      S_FETCH: begin
        alu_src_b_o = SRC_B_FOUR;
        ir_write_o  = ready;
        pc_write_o  = ready;
      end
      S_DECODE:    alu_src_b_o = SRC_B_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEM_READ:  i_or_d_o = 1'b1;
      S_MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d_o    = 1'b1;
        mem_write_o = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_src_o        = PC_SRC_ALU_OUT;
        pc_write_cond_o = 1'b1;
      end
      S_IMM_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = is_logic_imm(op_q) ? ALU_IMM_LOGIC : ALU_ADD;
      end
      S_IMM_WB:    reg_write_o = 1'b1;
      S_JUMP: begin
        pc_src_o   = PC_SRC_JUMP;
        pc_write_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// cycle by cycle and compares state and packed controls to hand values.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_write_o, ir_write_o;
  logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, logic_ext_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic [3:0] state_o;
  logic [15:0] ctrl;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.MEM_WAIT_EN(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_i        (opcode_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .i_or_d_o        (i_or_d_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_dst_o       (reg_dst_o),
    .reg_write_o     (reg_write_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_src_o        (pc_src_o),
    .logic_ext_o     (logic_ext_o),
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: pcw pcc iod mw irw m2r rd rw asa asb[1:0] aop[1:0] psrc[1:0] lx
  assign ctrl = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_write_o, ir_write_o,
                 mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
                 alu_src_b_o, alu_op_o, pc_src_o, logic_ext_o};

  localparam logic [15:0] C_FETCH0  = 16'b0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_FETCH1  = 16'b1_0_0_0_1_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_DECODE  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] C_MADDR   = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] C_MREAD   = 16'b0_0_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_MWB     = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] C_MWRITE  = 16'b0_0_1_1_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_REXEC   = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] C_RWB     = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] C_BRANCH  = 16'b0_1_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] C_ADDI_EX = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] C_LOGI_EX = 16'b0_0_0_0_0_0_0_0_1_10_11_00_1;
  localparam logic [15:0] C_ADDI_WB = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [15:0] C_LOGI_WB = 16'b0_0_0_0_0_0_0_1_0_00_00_00_1;
  localparam logic [15:0] C_JUMP    = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check, then advance.
  task automatic cyc(input string tag, input logic ready, input logic [5:0] op,
                     input logic [3:0] exp_state, input logic [15:0] exp_ctrl);
    mem_ready_i = ready;
    opcode_i    = op;
    #1;
    check({tag, ".state"}, {12'd0, state_o}, {12'd0, exp_state});
    check({tag, ".ctrl"}, ctrl, exp_ctrl);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    mem_ready_i = 1'b0;
    opcode_i    = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset.state", {12'd0, state_o}, 16'd0);
    check("reset.ctrl", ctrl, C_FETCH0);
    @(negedge clk);
    reset = 1'b0;

    // FETCH stalls two cycles on memory, then completes.
    cyc("fetch_w0", 1'b0, 6'h00, 4'd0, C_FETCH0);
    cyc("fetch_w1", 1'b0, 6'h00, 4'd0, C_FETCH0);
    cyc("fetch_go", 1'b1, 6'h00, 4'd0, C_FETCH1);

    // Unknown opcode: DECODE then straight back to FETCH.
    cyc("nop_dec",   1'b1, 6'h3F, 4'd1, C_DECODE);
    cyc("nop_fetch", 1'b1, 6'h00, 4'd0, C_FETCH1);

    // andi; opcode_i changes after DECODE to prove the latched value is used.
    cyc("andi_dec",  1'b1, 6'h0C, 4'd1,  C_DECODE);
    cyc("andi_ex",   1'b1, 6'h00, 4'd9,  C_LOGI_EX);
    cyc("andi_wb",   1'b1, 6'h00, 4'd10, C_LOGI_WB);
    cyc("andi_done", 1'b1, 6'h00, 4'd0,  C_FETCH1);

    // lw with three wait cycles in MEM_READ.
    cyc("lw_dec",   1'b1, 6'h23, 4'd1, C_DECODE);
    cyc("lw_addr",  1'b1, 6'h23, 4'd2, C_MADDR);
    cyc("lw_rd_w0", 1'b0, 6'h23, 4'd3, C_MREAD);
    cyc("lw_rd_w1", 1'b0, 6'h23, 4'd3, C_MREAD);
    cyc("lw_rd_w2", 1'b0, 6'h23, 4'd3, C_MREAD);
    cyc("lw_rd_go", 1'b1, 6'h23, 4'd3, C_MREAD);
    cyc("lw_wb",    1'b1, 6'h23, 4'd4, C_MWB);
    cyc("lw_done",  1'b1, 6'h00, 4'd0, C_FETCH1);

    // sw
    cyc("sw_dec",  1'b1, 6'h2B, 4'd1, C_DECODE);
    cyc("sw_addr", 1'b1, 6'h2B, 4'd2, C_MADDR);
    cyc("sw_wr",   1'b1, 6'h2B, 4'd5, C_MWRITE);
    cyc("sw_done", 1'b1, 6'h00, 4'd0, C_FETCH1);

    // R-type
    cyc("r_dec",  1'b1, 6'h00, 4'd1, C_DECODE);
    cyc("r_ex",   1'b1, 6'h00, 4'd6, C_REXEC);
    cyc("r_wb",   1'b1, 6'h00, 4'd7, C_RWB);
    cyc("r_done", 1'b1, 6'h00, 4'd0, C_FETCH1);

    // addi (sign-extended, add)
    cyc("addi_dec", 1'b1, 6'h08, 4'd1,  C_DECODE);
    cyc("addi_ex",  1'b1, 6'h08, 4'd9,  C_ADDI_EX);
    cyc("addi_wb",  1'b1, 6'h08, 4'd10, C_ADDI_WB);
    cyc("addi_done", 1'b1, 6'h00, 4'd0, C_FETCH1);

    // ori
    cyc("ori_dec", 1'b1, 6'h0D, 4'd1,  C_DECODE);
    cyc("ori_ex",  1'b1, 6'h0D, 4'd9,  C_LOGI_EX);
    cyc("ori_wb",  1'b1, 6'h0D, 4'd10, C_LOGI_WB);
    cyc("ori_done", 1'b1, 6'h00, 4'd0, C_FETCH1);

    // beq
    cyc("beq_dec",  1'b1, 6'h04, 4'd1, C_DECODE);
    cyc("beq_br",   1'b1, 6'h04, 4'd8, C_BRANCH);
    cyc("beq_done", 1'b1, 6'h00, 4'd0, C_FETCH1);

    // j
    cyc("j_dec",  1'b1, 6'h02, 4'd1,  C_DECODE);
    cyc("j_jmp",  1'b1, 6'h02, 4'd11, C_JUMP);
    cyc("j_done", 1'b1, 6'h00, 4'd0,  C_FETCH1);

    // Asynchronous reset in the middle of a stalled MEM_READ.
    cyc("rst_lw_dec",  1'b1, 6'h23, 4'd1, C_DECODE);
    cyc("rst_lw_addr", 1'b1, 6'h23, 4'd2, C_MADDR);
    mem_ready_i = 1'b0;
    #1;
    check("rst_lw_rd.state", {12'd0, state_o}, 16'd3);
    #1 reset = 1'b1;
    #1;
    check("rst_async.state", {12'd0, state_o}, 16'd0);
    check("rst_async.ctrl", ctrl, C_FETCH0);
    @(negedge clk);
    #1;
    check("rst_hold.state", {12'd0, state_o}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc("rst_fetch", 1'b1, 6'h00, 4'd0, C_FETCH1);
    cyc("rst_r_dec", 1'b1, 6'h00, 4'd1, C_DECODE);
    cyc("rst_r_ex",  1'b1, 6'h00, 4'd6, C_REXEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
